// File: rtl/imm_pipe.sv
// imm_pipe: decodes immediate, format code and illegal flag from a raw RV32I/RV64I word
//   and queues them with a pass-through tag in a 2-entry in-order buffer.
// Latency: 1 edge from input handshake to head (buffer empty or head popping that edge).
// Backpressure: in_ready = (count < 2) from registered count only; out_* come from registers.
// Ports: clk, rst_n (async active-low), flush (synchronous clear);
//   in_valid/in_ready/in_instr/in_tag   - input handshake and payload;
//   out_valid/out_ready/out_imm/out_fmt/out_illegal/out_tag - head entry handshake and payload.
module imm_pipe #(
  parameter int XLEN  = 32,  // 32 or 64
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE  = 3'b000;
  localparam logic [2:0] FMT_I     = 3'b001;
  localparam logic [2:0] FMT_S     = 3'b010;
  localparam logic [2:0] FMT_B     = 3'b011;
  localparam logic [2:0] FMT_U     = 3'b100;
  localparam logic [2:0] FMT_J     = 3'b101;
  localparam logic [2:0] FMT_SHAMT = 3'b110;
  localparam logic [2:0] FMT_ZIMM  = 3'b111;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ---------------------------------------------------------------------------
  // Decode (combinational on in_instr)
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     raw32;    // immediate already sign/zero-extended to 32 bits
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_imm;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  always_comb begin
    raw32   = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        raw32   = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        raw32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_MISC: begin
        dec_fmt = FMT_I;
        raw32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        raw32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        raw32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            raw32 = {26'b0, in_instr[25:20]};
          end else begin
            // RV32 shifts only have a 5-bit amount; bit 25 set is reserved.
            raw32   = {27'b0, in_instr[24:20]};
            dec_ill = in_instr[25];
          end
        end else begin
          dec_fmt = FMT_I;
          raw32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec_fmt = FMT_ZIMM;
          raw32   = {27'b0, in_instr[19:15]};
        end
      end
      OP_REG: begin
        dec_fmt = FMT_NONE;
      end
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // Zero-extended fields are narrow, so bit 31 of raw32 is 0 for them and a
  // single sign extension to XLEN is correct for every format.
  always_comb begin
    if (dec_ill) dec_imm = '0;
    else         dec_imm = XLEN'($signed(raw32));
  end

  // ---------------------------------------------------------------------------
  // 2-entry in-order buffer
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  imm_q [2];
  logic [2:0]       fmt_q [2];
  logic             ill_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      // flush wins over any handshake completing this cycle
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        fmt_q[i] <= FMT_NONE;
        ill_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push && !flush) begin
        imm_q[wr_ptr_q] <= dec_imm;
        fmt_q[wr_ptr_q] <= dec_fmt;
        ill_q[wr_ptr_q] <= dec_ill;
        tag_q[wr_ptr_q] <= in_tag;
      end
    end
  end

  // Head outputs read 0 whenever the buffer is empty.
  assign out_imm     = out_valid ? imm_q[rd_ptr_q] : '0;
  assign out_fmt     = out_valid ? fmt_q[rd_ptr_q] : FMT_NONE;
  assign out_illegal = out_valid ? ill_q[rd_ptr_q] : 1'b0;
  assign out_tag     = out_valid ? tag_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_imm_pipe.sv
// tb_imm_pipe: drives an XLEN=32 and an XLEN=64 instance with identical stimulus
//   and compares both heads every cycle against a queue-based reference model.
module tb_imm_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [2:0]  out_fmt64;

  imm_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_ill32), .out_tag(out_tag32)
  );

  imm_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_ill64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] tag;
  } ent_t;

  ent_t mq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // directed vectors: instr, expected {imm, fmt, illegal} for XLEN=32 and XLEN=64
  logic [31:0] dv_instr [7];
  logic [63:0] dv_imm32 [7];
  logic [63:0] dv_imm64 [7];
  logic [2:0]  dv_fmt32 [7];
  logic [2:0]  dv_fmt64 [7];
  logic        dv_ill32 [7];
  logic        dv_ill64 [7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // two's-complement interpretation of a bits-wide field
  function automatic longint sx(input longint v, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (v >= half) ? v - (half << 1) : v;
  endfunction

  function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint u;
    longint f3;
    longint v;
    u   = longint'({32'b0, w});
    f3  = (u >> 12) & 7;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (w[6:0])
      7'h37, 7'h17: begin fmt = 3'd4; v = sx(u & 64'hFFFFF000, 32); end
      7'h6F: begin
        fmt = 3'd5;
        v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
               (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
      end
      7'h67, 7'h03, 7'h0F: begin fmt = 3'd1; v = sx((u >> 20) & 4095, 12); end
      7'h23: begin fmt = 3'd2; v = sx((((u >> 25) & 127) << 5) | ((u >> 7) & 31), 12); end
      7'h63: begin
        fmt = 3'd3;
        v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
               (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
      end
      7'h13: begin
        if (f3 == 1 || f3 == 5) begin
          fmt = 3'd6;
          if (xlen == 64) v = (u >> 20) & 63;
          else begin
            v   = (u >> 20) & 31;
            ill = (((u >> 25) & 1) == 1);
          end
        end else begin
          fmt = 3'd1;
          v = sx((u >> 20) & 4095, 12);
        end
      end
      7'h73: begin
        if (f3 >= 4) begin fmt = 3'd7; v = (u >> 15) & 31; end
      end
      7'h33: v = 0;
      default: ill = 1'b1;
    endcase
    if (ill) v = 0;
    imm = (xlen == 32) ? (v & 64'hFFFFFFFF) : v;
  endfunction

  task automatic check_all();
    logic [63:0] e32, e64;
    logic [2:0]  f32, f64;
    logic        i32, i64, ev, er;
    logic [31:0] t;
    e32 = '0; e64 = '0; f32 = '0; f64 = '0; i32 = 1'b0; i64 = 1'b0; t = '0;
    ev = (mq.size() > 0);
    er = (mq.size() < 2);
    if (ev) begin
      ref_decode(mq[0].instr, 32, e32, f32, i32);
      ref_decode(mq[0].instr, 64, e64, f64, i64);
      t = mq[0].tag;
    end
    chk("valid32", {63'b0, out_valid32}, {63'b0, ev});
    chk("ready32", {63'b0, in_ready32},  {63'b0, er});
    chk("imm32",   {32'b0, out_imm32},   e32);
    chk("fmt32",   {61'b0, out_fmt32},   {61'b0, f32});
    chk("ill32",   {63'b0, out_ill32},   {63'b0, i32});
    chk("tag32",   {32'b0, out_tag32},   {32'b0, t});
    chk("valid64", {63'b0, out_valid64}, {63'b0, ev});
    chk("ready64", {63'b0, in_ready64},  {63'b0, er});
    chk("imm64",   out_imm64,            e64);
    chk("fmt64",   {61'b0, out_fmt64},   {61'b0, f64});
    chk("ill64",   {63'b0, out_ill64},   {63'b0, i64});
    chk("tag64",   {32'b0, out_tag64},   {32'b0, t});
  endtask

  // one clock: update the model from pre-edge inputs, then check after the edge
  task automatic step();
    bit do_push, do_pop;
    ent_t e;
    do_push = in_valid && (mq.size() < 2);
    do_pop  = out_ready && (mq.size() > 0);
    e.instr = in_instr;
    e.tag   = in_tag;
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
    check_all();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 12))
      0:  w[6:0] = 7'h37;
      1:  w[6:0] = 7'h17;
      2:  w[6:0] = 7'h6F;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h03;
      5:  w[6:0] = 7'h0F;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h63;
      8:  w[6:0] = 7'h13;
      9:  w[6:0] = 7'h73;
      10: w[6:0] = 7'h33;
      11: w[6:0] = 7'h13;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    dv_instr = '{32'hFFF00093, 32'hFE20AE23, 32'h123452B7, 32'h01F09093,
                 32'h3002D073, 32'h0000007F, 32'h03F09093};
    dv_imm32 = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'h12345000, 64'h1F, 64'h5, 64'h0, 64'h0};
    dv_fmt32 = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7, 3'd0, 3'd6};
    dv_ill32 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    dv_imm64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h12345000,
                 64'h1F, 64'h5, 64'h0, 64'h3F};
    dv_fmt64 = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd7, 3'd0, 3'd6};
    dv_ill64 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // ---- reset values
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_tag = '0;
    #1 rst_n = 1'b0;
    #2 check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed decode vectors, out_ready high, each visible one edge later
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_instr = dv_instr[i];
      in_tag   = 32'h1000 + 32'(i * 4);
      step();
      chk("dir_vld",   {63'b0, out_valid32}, 64'd1);
      chk("dir_imm32", {32'b0, out_imm32}, dv_imm32[i]);
      chk("dir_fmt32", {61'b0, out_fmt32}, {61'b0, dv_fmt32[i]});
      chk("dir_ill32", {63'b0, out_ill32}, {63'b0, dv_ill32[i]});
      chk("dir_imm64", out_imm64, dv_imm64[i]);
      chk("dir_fmt64", {61'b0, out_fmt64}, {61'b0, dv_fmt64[i]});
      chk("dir_ill64", {63'b0, out_ill64}, {63'b0, dv_ill64[i]});
    end
    in_valid = 1'b0;
    step();

    // ---- backpressure: A, B fill the buffer, C is held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_tag = 32'hA;  step();
    in_instr = 32'h00200113; in_tag = 32'hB;                   step();
    chk("bp_ready_full", {63'b0, in_ready32}, 64'd0);
    in_instr = 32'h00300193; in_tag = 32'hC;                   step();
    chk("bp_head_A", {32'b0, out_tag32}, 64'hA);
    out_ready = 1'b1;                                          step();
    chk("bp_head_B", {32'b0, out_tag32}, 64'hB);
    step();
    chk("bp_head_C", {32'b0, out_tag32}, 64'hC);
    in_valid = 1'b0;                                           step();
    chk("bp_empty", {63'b0, out_valid32}, 64'd0);

    // ---- flush while full, with pop and push attempt in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00400213; in_tag = 32'hD0; step();
    in_tag = 32'hD1;                                           step();
    flush = 1'b1; out_ready = 1'b1; in_tag = 32'hDF;           step();
    chk("flush_full_vld", {63'b0, out_valid64}, 64'd0);
    // flush with one entry and a real same-cycle push
    flush = 1'b0; out_ready = 1'b0; in_tag = 32'hE0;           step();
    flush = 1'b1; in_tag = 32'hEF;                             step();
    chk("flush_push_vld", {63'b0, out_valid32}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // ---- randomized traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_instr  = rand_instr();
      in_tag    = $urandom;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // ---- asynchronous reset while full and stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h51; step();
    in_tag = 32'h52;                                            step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    #1;
    check_all();
    chk("rst_ready", {63'b0, in_ready64}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_instr = 32'h123452B7; in_tag = 32'h77;  step();
    chk("post_rst_imm", {32'b0, out_imm32}, 64'h12345000);
    in_valid = 1'b0; out_ready = 1'b1;                          step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
